// File: rtl/traffic_gen_chk_pkg.sv
// Shared encodings for the traffic generator/checker: pop modes, FSM states and PRBS taps.
package traffic_gen_chk_pkg;

    typedef enum logic [1:0] {
        POP_OFF       = 2'd0,
        POP_ALWAYS    = 2'd1,
        POP_ALTERNATE = 2'd2,
        POP_PRBS      = 2'd3
    } pop_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/traffic_gen_chk_seq_checker.sv
// Per-destination in-order checker: registers pop acceptance, compares the word
// returned one cycle later against {IDX, exp} and resyncs exp on a mismatch.
module traffic_gen_chk_seq_checker #(
    parameter int DATA_W = 6,
    parameter int DEST_W = 1,
    parameter int SEQ_W  = 5,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_pop,
    input  logic              i_empty,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rx,
    output logic              o_err
);

    localparam logic [DEST_W-1:0] DEST_ID = DEST_W'(IDX);

    logic             r_vld_p1;
    logic [SEQ_W-1:0] r_exp;
    logic             w_match;

    assign w_match = (i_data == {DEST_ID, r_exp});
    assign o_rx    = r_vld_p1;
    assign o_err   = r_vld_p1 && !w_match;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_vld_p1 <= 1'b0;
            r_exp    <= '0;
        end else begin
            // stage p0 -> p1: acceptance of a pop on a non-empty FIFO
            r_vld_p1 <= i_pop && !i_empty;
            if (r_vld_p1) begin
                r_exp <= w_match ? r_exp + SEQ_W'(1) : i_data[SEQ_W-1:0] + SEQ_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_gen_chk.sv
// Backpressure-aware stimulus generator and N-destination in-order checker for the
// interconnect device: pushes tagged words, drives pop patterns, counts rx and errors.
module traffic_gen_chk
    import traffic_gen_chk_pkg::*;
#(
    parameter int         DATA_W        = 6,
    parameter int         N_DEST        = 2,
    parameter int         CNT_W         = 8,
    parameter int         POP_HALF      = 4,
    parameter int         DRAIN_TIMEOUT = 64,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_words,
    input  logic [1:0]               pop_mode,
    input  logic                     pause_i,
    output logic [DATA_W-1:0]        data_in_o,
    output logic                     push_o,
    output logic [N_DEST-1:0]        pop_o,
    input  logic [N_DEST-1:0]        empty_i,
    input  logic [N_DEST*DATA_W-1:0] data_out_i,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         tx_cnt,
    output logic [CNT_W-1:0]         rx_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt
);

    localparam int DEST_W = (N_DEST > 1) ? $clog2(N_DEST) : 1;
    localparam int SEQ_W  = DATA_W - DEST_W;
    localparam int PH_W   = $clog2(POP_HALF + 1);
    localparam int DT_W   = $clog2(DRAIN_TIMEOUT + 1);

    state_e            r_state;
    pop_mode_e         r_mode;
    logic [CNT_W-1:0]  r_num;
    logic [DEST_W-1:0] r_dest;
    logic [SEQ_W-1:0]  r_seq [N_DEST];
    logic [PH_W-1:0]   r_ph;
    logic              r_alt;
    logic [7:0]        r_lfsr;
    logic [DT_W-1:0]   r_drain_cnt;

    logic              w_start_ok;
    logic              w_lvl_nxt;
    logic [7:0]        w_lfsr_nxt;
    logic [N_DEST-1:0] w_rx;
    logic [N_DEST-1:0] w_err;
    logic [CNT_W-1:0]  w_rx_inc;
    logic [CNT_W-1:0]  w_err_inc;

    function automatic logic [N_DEST-1:0] pop_pattern(input pop_mode_e mode, input logic lvl,
                                                      input logic [7:0] lfsr);
        logic [N_DEST-1:0] p;
        p = '0;
        for (int i = 0; i < N_DEST; i++) begin
            case (mode)
                POP_ALWAYS:    p[i] = 1'b1;
                POP_ALTERNATE: p[i] = lvl ^ i[0];
                POP_PRBS:      p[i] = lfsr[i % 8];
                default:       p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_lvl_nxt  = (r_ph == PH_W'(POP_HALF)) ? !r_alt : r_alt;
    assign w_lfsr_nxt = lfsr_step(r_lfsr);
    assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);

    for (genvar gi = 0; gi < N_DEST; gi++) begin : g_chk
        traffic_gen_chk_seq_checker #(
            .DATA_W (DATA_W),
            .DEST_W (DEST_W),
            .SEQ_W  (SEQ_W),
            .IDX    (gi)
        ) u_chk (
            .clk     (clk),
            .reset   (reset),
            .i_clr   (w_start_ok),
            .i_pop   (pop_o[gi]),
            .i_empty (empty_i[gi]),
            .i_data  (data_out_i[gi*DATA_W +: DATA_W]),
            .o_rx    (w_rx[gi]),
            .o_err   (w_err[gi])
        );
    end

    always_comb begin
        w_rx_inc  = '0;
        w_err_inc = '0;
        for (int i = 0; i < N_DEST; i++) begin
            w_rx_inc  = w_rx_inc + CNT_W'(w_rx[i]);
            w_err_inc = w_err_inc + CNT_W'(w_err[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mode       <= POP_OFF;
            r_num        <= '0;
            r_dest       <= '0;
            r_ph         <= '0;
            r_alt        <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_drain_cnt  <= '0;
            data_in_o    <= '0;
            push_o       <= 1'b0;
            pop_o        <= '0;
            timeout      <= 1'b0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            mismatch_cnt <= '0;
            for (int i = 0; i < N_DEST; i++) r_seq[i] <= '0;
        end else begin
            r_lfsr       <= w_lfsr_nxt;
            rx_cnt       <= rx_cnt + w_rx_inc;
            mismatch_cnt <= sat_add(mismatch_cnt, w_err_inc);
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_mode       <= pop_mode_e'(pop_mode);
                        r_num        <= num_words;
                        r_dest       <= '0;
                        r_ph         <= PH_W'(1);
                        r_alt        <= 1'b0;
                        r_drain_cnt  <= '0;
                        timeout      <= 1'b0;
                        tx_cnt       <= '0;
                        rx_cnt       <= '0;
                        mismatch_cnt <= '0;
                        pop_o        <= pop_pattern(pop_mode_e'(pop_mode), 1'b0, w_lfsr_nxt);
                        for (int i = 0; i < N_DEST; i++) r_seq[i] <= '0;
                    end
                end
                ST_RUN: begin
                    r_alt  <= w_lvl_nxt;
                    r_ph   <= (r_ph == PH_W'(POP_HALF)) ? PH_W'(1) : r_ph + PH_W'(1);
                    push_o <= 1'b0;
                    pop_o  <= pop_pattern(r_mode, w_lvl_nxt, w_lfsr_nxt);
                    if (tx_cnt == r_num) begin
                        r_state <= ST_DRAIN;
                        pop_o   <= '1;
                    end else if (!pause_i) begin
                        // tx_cnt counts the word being placed on the bus this edge
                        push_o        <= 1'b1;
                        data_in_o     <= {r_dest, r_seq[r_dest]};
                        r_seq[r_dest] <= r_seq[r_dest] + SEQ_W'(1);
                        r_dest        <= (r_dest == DEST_W'(N_DEST - 1)) ? '0 : r_dest + DEST_W'(1);
                        tx_cnt        <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + DT_W'(1);
                    if (rx_cnt == tx_cnt) begin
                        r_state <= ST_DONE;
                        pop_o   <= '0;
                    end else if (r_drain_cnt == DT_W'(DRAIN_TIMEOUT - 1)) begin
                        r_state <= ST_DONE;
                        timeout <= 1'b1;
                        pop_o   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
